// File: rtl/fir_tap_seq.sv
`default_nettype none
// ============================================================================
// Module  : fir_tap_seq
// Brief   : Control sequencer for an SRL16E delay line and its MAC: shift-in,
//           tap address sweep, delayed accumulator clear/enable, result strobe.
// Rev     : 1.0
// ============================================================================
module fir_tap_seq #(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] ntaps_m1,
  input  logic       in_stb,
  output logic       in_rdy,
  output logic       sr_ce,
  output logic [3:0] sr_a,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       out_stb,
  output logic       ovr,
  input  logic       ovr_clr
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SHIFT = 3'd1;
  localparam logic [2:0] c_RUN   = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [3:0] c_DRAIN_LAST = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  logic [2:0] state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [3:0] n_q, n_d;
  logic       ovr_q, ovr_d;
  logic       w_rdy;
  logic       w_run;
  logic       w_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      ovr_q   <= ovr_d;
    end
  end

  // k_q counts taps in RUN and is reused as the drain-cycle counter in DRAIN
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    if (!en) begin
      state_d = c_IDLE;
      k_d     = '0;
    end else begin
      case (state_q)
        c_IDLE: begin
          if (in_stb) begin
            state_d = c_SHIFT;
            n_d     = ntaps_m1;
            k_d     = '0;
          end
        end
        c_SHIFT: begin
          state_d = c_RUN;
          k_d     = '0;
        end
        c_RUN: begin
          if (k_q == n_q) begin
            k_d     = '0;
            state_d = (LAT == 0) ? c_DONE : c_DRAIN;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
        c_DRAIN: begin
          if (k_q == c_DRAIN_LAST) begin
            k_d     = '0;
            state_d = c_DONE;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
        c_DONE: begin
          state_d = c_IDLE;
        end
        default: begin
          state_d = c_IDLE;
          k_d     = '0;
        end
      endcase
    end
  end

  // A strobe that cannot be accepted sets the flag; set dominates clear
  assign w_rdy = (state_q == c_IDLE) && en;
  assign ovr_d = (in_stb && !w_rdy) || (ovr_q && !ovr_clr);

  always_comb begin
    in_rdy  = w_rdy && rst_n;
    sr_ce   = (state_q == c_SHIFT);
    w_run   = (state_q == c_RUN);
    w_first = w_run && (k_q == 4'd0);
    sr_a    = w_run ? k_q : 4'd0;
    out_stb = (state_q == c_DONE);
    ovr     = ovr_q;
  end

  generate
    if (LAT == 0) begin : g_lat_zero
      assign acc_en  = w_run;
      assign acc_clr = w_first;
    end else begin : g_lat_pipe
      logic [LAT-1:0] en_pipe_q;
      logic [LAT-1:0] clr_pipe_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          en_pipe_q  <= '0;
          clr_pipe_q <= '0;
        end else if (!en) begin
          en_pipe_q  <= '0;
          clr_pipe_q <= '0;
        end else begin
          en_pipe_q[0]  <= w_run;
          clr_pipe_q[0] <= w_first;
          for (int i = 1; i < LAT; i++) begin
            en_pipe_q[i]  <= en_pipe_q[i-1];
            clr_pipe_q[i] <= clr_pipe_q[i-1];
          end
        end
      end

      assign acc_en  = en_pipe_q[LAT-1];
      assign acc_clr = clr_pipe_q[LAT-1];
    end
  endgenerate

endmodule
`default_nettype wire
